// File: rtl/counter_ctrl_pkg.sv
// Shared types and default parameters for the counter_ctrl sequencer.
// The ERR state is always part of the encoding; it is reachable only with COUNTER_CTRL_CHECK_EN.
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN_ON  = 3'd2,
        ST_RUN_OFF = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } counter_ctrl_state_t;

    localparam int unsigned DEF_WIDTH      = 3;
    localparam int unsigned DEF_ON_CYCLES  = 6;
    localparam int unsigned DEF_OFF_CYCLES = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/duty_timer.sv
// Loadable down-counter with a zero flag; times both the ON and OFF duty phases.
module duty_timer
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned TW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] value;

    // Saturates at zero so a phase that outlives its timer simply stays expired.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - TW'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller: clears an external up-counter, duty-cycles its enable, stops at target.
// Optional stall checker (err port, ERR state) enabled by defining COUNTER_CTRL_CHECK_EN.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done
`ifdef COUNTER_CTRL_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int unsigned    TW       = $clog2(max_u(ON_CYCLES, OFF_CYCLES) + 1);
    localparam logic [TW-1:0]  ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]  OFF_LOAD = (OFF_CYCLES == 0) ? '0 : TW'(OFF_CYCLES - 1);

    counter_ctrl_state_t state_q, state_d;

    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] tgt_m1;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_zero;
    logic             slip;

    // Only consulted in RUN_ON, which is entered only with a nonzero target.
    assign tgt_m1 = tgt_q - WIDTH'(1);

    duty_timer #(
        .TW(TW)
    ) u_duty_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

`ifdef COUNTER_CTRL_CHECK_EN
    logic [WIDTH-1:0] prev_count;
    logic             prev_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_count <= '0;
            prev_en    <= 1'b0;
        end else begin
            prev_count <= count;
            prev_en    <= cnt_en;
        end
    end

    assign slip = (state_q == ST_RUN_ON) && prev_en && (count != prev_count + WIDTH'(1));
`else
    assign slip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = ON_LOAD;
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (tgt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_RUN_ON;
                        tmr_load = 1'b1;
                        tmr_val  = ON_LOAD;
                    end
                end
                ST_RUN_ON: begin
                    if (slip) begin
                        state_d = ST_ERR;
                    end else if (count == tgt_m1) begin
                        state_d = ST_DONE;
                    end else if (tmr_zero) begin
                        tmr_load = 1'b1;
                        if (OFF_CYCLES == 0) begin
                            tmr_val = ON_LOAD;
                        end else begin
                            state_d = ST_RUN_OFF;
                            tmr_val = OFF_LOAD;
                        end
                    end
                end
                ST_RUN_OFF: begin
                    if (tmr_zero) begin
                        state_d  = ST_RUN_ON;
                        tmr_load = 1'b1;
                        tmr_val  = ON_LOAD;
                    end
                end
                ST_DONE: begin
                    if (start) state_d = ST_CLEAR;
                end
`ifdef COUNTER_CTRL_CHECK_EN
                ST_ERR: state_d = ST_ERR;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Target is captured on every entry into CLEAR, covering both IDLE and DONE restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_q <= '0;
        end else if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) begin
            tgt_q <= target;
        end
    end

    // Outputs are registered images of the state being entered, so they track the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cnt_en  <= (state_d == ST_RUN_ON);
            cnt_clr <= (state_d == ST_CLEAR);
            busy    <= (state_d == ST_CLEAR) || (state_d == ST_RUN_ON) || (state_d == ST_RUN_OFF);
            done    <= (state_d == ST_DONE);
        end
    end

`ifdef COUNTER_CTRL_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else begin
            err <= (state_d == ST_ERR);
        end
    end
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: a cycle table for the default duty pattern plus
// hand sequences for continuous enable, async reset and (with COUNTER_CTRL_CHECK_EN) stall detection.
module tb_counter_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, stop0 = 1'b0, hold0 = 1'b0;
    logic [2:0] target0 = '0, count0;
    logic       en0, clr0, busy0, done0;
    logic       start1 = 1'b0, stop1 = 1'b0;
    logic [2:0] target1 = '0, count1;
    logic       en1, clr1, busy1, done1;
`ifdef COUNTER_CTRL_CHECK_EN
    logic       err0, err1;
`endif

    counter_ctrl #(.WIDTH(3), .ON_CYCLES(6), .OFF_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(rst_n), .start(start0), .stop(stop0), .target(target0),
        .count(count0), .cnt_en(en0), .cnt_clr(clr0), .busy(busy0), .done(done0)
`ifdef COUNTER_CTRL_CHECK_EN
        , .err(err0)
`endif
    );

    counter_ctrl #(.WIDTH(3), .ON_CYCLES(6), .OFF_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .stop(stop1), .target(target1),
        .count(count1), .cnt_en(en1), .cnt_clr(clr1), .busy(busy1), .done(done1)
`ifdef COUNTER_CTRL_CHECK_EN
        , .err(err1)
`endif
    );

    // Counter models; hold0 makes counter 0 ignore one enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 count0 <= '0;
        else if (clr0)              count0 <= '0;
        else if (en0 && !hold0)     count0 <= count0 + 3'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 count1 <= '0;
        else if (clr1)              count1 <= '0;
        else if (en1)               count1 <= count1 + 3'd1;
    end

    typedef struct {
        logic [4:0] in;   // {start, stop, target}
        logic [6:0] exp;  // {cnt_en, cnt_clr, busy, done, count}
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add_vec(input logic [4:0] in, input logic [6:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got en/clr/busy/done/count=%b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // One record per cycle: outputs expected in that cycle, inputs driven for its closing edge.
        add_vec(5'b1_0_101, 7'b0_0_0_0_000); // c0  start, target 5
        add_vec(5'b0_0_000, 7'b0_1_1_0_000); // c1  CLEAR
        add_vec(5'b0_0_000, 7'b1_0_1_0_000); // c2
        add_vec(5'b0_0_000, 7'b1_0_1_0_001);
        add_vec(5'b0_0_000, 7'b1_0_1_0_010);
        add_vec(5'b0_0_000, 7'b1_0_1_0_011);
        add_vec(5'b0_0_000, 7'b1_0_1_0_100); // c6  count == target-1
        add_vec(5'b0_0_000, 7'b0_0_0_1_101); // c7  DONE
        add_vec(5'b1_0_111, 7'b0_0_0_1_101); // c8  restart from DONE, target 7
        add_vec(5'b0_0_000, 7'b0_1_1_0_101); // c9  CLEAR
        add_vec(5'b0_0_000, 7'b1_0_1_0_000); // c10
        add_vec(5'b0_0_000, 7'b1_0_1_0_001);
        add_vec(5'b0_0_000, 7'b1_0_1_0_010);
        add_vec(5'b0_0_000, 7'b1_0_1_0_011);
        add_vec(5'b0_0_000, 7'b1_0_1_0_100);
        add_vec(5'b0_0_000, 7'b1_0_1_0_101); // c15 last ON cycle
        add_vec(5'b0_0_000, 7'b0_0_1_0_110); // c16 OFF
        add_vec(5'b0_0_000, 7'b0_0_1_0_110); // c17 OFF
        add_vec(5'b0_0_000, 7'b1_0_1_0_110); // c18 ON, final enable
        add_vec(5'b0_0_000, 7'b0_0_0_1_111); // c19 DONE, count 7
        add_vec(5'b0_1_000, 7'b0_0_0_1_111); // c20 stop in DONE
        add_vec(5'b1_1_011, 7'b0_0_0_0_111); // c21 start+stop in IDLE
        add_vec(5'b1_0_000, 7'b0_0_0_0_111); // c22 still IDLE; start target 0
        add_vec(5'b0_0_000, 7'b0_1_1_0_111); // c23 CLEAR
        add_vec(5'b1_0_111, 7'b0_0_0_1_000); // c24 DONE at once; restart target 7
        add_vec(5'b0_0_000, 7'b0_1_1_0_000); // c25 CLEAR
        add_vec(5'b0_0_000, 7'b1_0_1_0_000); // c26
        add_vec(5'b0_1_000, 7'b1_0_1_0_001); // c27 stop mid-run
        add_vec(5'b0_0_000, 7'b0_0_0_0_010); // c28 IDLE, count holds
        add_vec(5'b0_0_000, 7'b0_0_0_0_010); // c29

        tick();
        tick();
        rst_n = 1'b1;

        chk("reset_dut1", {en1, clr1, busy1, done1, count1}, 7'b0);
        for (int i = 0; i < vq.size(); i++) begin
            chk($sformatf("vec%0d", i), {en0, clr0, busy0, done0, count0}, vq[i].exp);
            start0  = vq[i].in[4];
            stop0   = vq[i].in[3];
            target0 = vq[i].in[2:0];
            tick();
        end
        start0 = 1'b0;
        stop0  = 1'b0;

        // Continuous enable: start at c0, a start at c4 must be ignored.
        start1  = 1'b1;
        target1 = 3'd7;
        for (int c = 1; c <= 10; c++) begin
            logic [6:0] e;
            tick();
            e[6]   = (c >= 2) && (c <= 8);
            e[5]   = (c == 1);
            e[4]   = (c >= 1) && (c <= 8);
            e[3]   = (c >= 9);
            e[2:0] = (c <= 2) ? 3'd0 : (c >= 9) ? 3'd7 : 3'(c - 2);
            chk($sformatf("cont_c%0d", c), {en1, clr1, busy1, done1, count1}, e);
            start1  = (c == 4) || (c == 10);
            target1 = (c == 4) ? 3'd2 : 3'd1;
        end
        tick();
        start1 = 1'b0;
        chk("cont_restart_clr", {en1, clr1, busy1, done1, count1}, 7'b0_1_1_0_111);
        tick();
        chk("cont_restart_en", {en1, clr1, busy1, done1, count1}, 7'b1_0_1_0_000);
        tick();
        chk("cont_restart_done", {en1, clr1, busy1, done1, count1}, 7'b0_0_0_1_001);

        // Asynchronous reset in the middle of a run.
        start0  = 1'b1;
        target0 = 3'd7;
        tick();
        start0 = 1'b0;
        tick();
        chk("pre_reset_run", {en0, clr0, busy0, done0, count0}, 7'b1_0_1_0_000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_dut0", {en0, clr0, busy0, done0, count0}, 7'b0);
        chk("async_reset_dut1", {en1, clr1, busy1, done1, count1}, 7'b0);
        tick();
        rst_n = 1'b1;

`ifdef COUNTER_CTRL_CHECK_EN
        chk("err_reset", {6'b0, err0}, 7'b0);
        start0  = 1'b1;
        target0 = 3'd7;
        tick();                 // c1
        start0 = 1'b0;
        tick();                 // c2
        tick();                 // c3
        hold0 = 1'b1;           // edge closing c3 does not count
        tick();                 // c4: count stalls at 1 with enable high
        hold0 = 1'b0;
        chk("stall_c4", {en0, clr0, busy0, done0, count0}, 7'b1_0_1_0_001);
        tick();                 // c5
        chk("err_c5", {en0, clr0, busy0, done0, err0, 2'b00}, 7'b0_0_0_0_1_00);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("err_sticky", {en0, clr0, busy0, done0, err0, 2'b00}, 7'b0_0_0_0_1_00);
        stop0 = 1'b1;
        tick();
        stop0 = 1'b0;
        chk("err_stop_idle", {en0, clr0, busy0, done0, err0, 2'b00}, 7'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
